// File: rtl/aes_round_sequencer.sv
// AES round sequencer: IDLE -> KEYLOAD (KEY_LAT cycles) -> ROUND (Nr+1 cycles) -> DONE; all outputs registered.
// out_valid rises KEY_LAT+Nr+1 edges after the edge sampling start and is held until out_ready; abort wins over everything.
module aes_round_sequencer #(
    parameter int KEY_LAT = 1,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             decrypt,
    input  logic [1:0]       key_size,
    input  logic             abort,
    input  logic             out_ready,
    output logic             busy,
    output logic             key_exp_en,
    output logic             data_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             first_round,
    output logic             last_round,
    output logic             out_valid,
    output logic             cfg_err
);
    localparam int CNT_W = $clog2(KEY_LAT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYLOAD = 2'd1,
        ROUND   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] key_cnt;
    logic             decrypt_q;
    logic [1:0]       key_size_q;
    logic [IDX_W-1:0] nr;

    always_comb begin
        case (key_size_q)
            2'b00:   nr = IDX_W'(10);
            2'b01:   nr = IDX_W'(12);
            default: nr = IDX_W'(14);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            key_cnt     <= '0;
            decrypt_q   <= 1'b0;
            key_size_q  <= 2'b00;
            busy        <= 1'b0;
            key_exp_en  <= 1'b0;
            data_en     <= 1'b0;
            round_idx   <= '0;
            first_round <= 1'b0;
            last_round  <= 1'b0;
            out_valid   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                key_cnt     <= '0;
                busy        <= 1'b0;
                key_exp_en  <= 1'b0;
                data_en     <= 1'b0;
                round_idx   <= '0;
                first_round <= 1'b0;
                last_round  <= 1'b0;
                out_valid   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (key_size == 2'b11) begin
                                cfg_err <= 1'b1;
                            end else begin
                                decrypt_q  <= decrypt;
                                key_size_q <= key_size;
                                state      <= KEYLOAD;
                                busy       <= 1'b1;
                                key_exp_en <= 1'b1;
                                key_cnt    <= CNT_W'(1);
                            end
                        end
                    end
                    KEYLOAD: begin
                        if (key_cnt == CNT_W'(KEY_LAT)) begin
                            state       <= ROUND;
                            key_exp_en  <= 1'b0;
                            data_en     <= 1'b1;
                            first_round <= 1'b1;
                            last_round  <= 1'b0;
                            round_idx   <= decrypt_q ? nr : '0;
                        end else begin
                            key_cnt <= key_cnt + CNT_W'(1);
                        end
                    end
                    ROUND: begin
                        first_round <= 1'b0;
                        if (last_round) begin
                            state      <= DONE;
                            data_en    <= 1'b0;
                            last_round <= 1'b0;
                            out_valid  <= 1'b1;
                        end else if (decrypt_q) begin
                            round_idx  <= round_idx - IDX_W'(1);
                            last_round <= (round_idx == IDX_W'(1));
                        end else begin
                            round_idx  <= round_idx + IDX_W'(1);
                            last_round <= (round_idx + IDX_W'(1) == nr);
                        end
                    end
                    DONE: begin
                        // round_idx keeps the final round number until the result is taken
                        if (out_ready) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            round_idx <= '0;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        key_cnt     <= '0;
                        busy        <= 1'b0;
                        key_exp_en  <= 1'b0;
                        data_en     <= 1'b0;
                        round_idx   <= '0;
                        first_round <= 1'b0;
                        last_round  <= 1'b0;
                        out_valid   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (KEY_LAT=1 and KEY_LAT=3) share all inputs.
module tb_aes_round_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       decrypt = 1'b0;
    logic [1:0] key_size = 2'b00;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;

    logic       busy_o[2];
    logic       ke_o[2];
    logic       de_o[2];
    logic [3:0] idx_o[2];
    logic       fr_o[2];
    logic       lr_o[2];
    logic       ov_o[2];
    logic       cfg_o[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.KEY_LAT(1), .IDX_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .key_size(key_size),
        .abort(abort), .out_ready(out_ready), .busy(busy_o[0]), .key_exp_en(ke_o[0]),
        .data_en(de_o[0]), .round_idx(idx_o[0]), .first_round(fr_o[0]), .last_round(lr_o[0]),
        .out_valid(ov_o[0]), .cfg_err(cfg_o[0])
    );

    aes_round_sequencer #(.KEY_LAT(3), .IDX_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .key_size(key_size),
        .abort(abort), .out_ready(out_ready), .busy(busy_o[1]), .key_exp_en(ke_o[1]),
        .data_en(de_o[1]), .round_idx(idx_o[1]), .first_round(fr_o[1]), .last_round(lr_o[1]),
        .out_valid(ov_o[1]), .cfg_err(cfg_o[1])
    );

    typedef struct {
        logic [1:0] key_size;
        logic       decrypt;
        int         nr;
        int         lat1;
        int         final_idx;
        bit         poke;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All outputs of one instance packed into one word; zero means fully idle.
    function automatic int outs(input int d);
        return {21'd0, busy_o[d], ke_o[d], de_o[d], fr_o[d], lr_o[d], ov_o[d], cfg_o[d], idx_o[d]};
    endfunction

    task automatic trace(input string name, input vec_t v);
        int  kc[2];
        int  dc[2];
        int  lat[2];
        int  fidx[2];
        bit  ok[2];
        bit  excl[2];
        int  e;
        for (int d = 0; d < 2; d++) begin
            kc[d] = 0; dc[d] = 0; lat[d] = -1; fidx[d] = -1; ok[d] = 1'b1; excl[d] = 1'b1;
        end
        key_size = v.key_size;
        decrypt  = v.decrypt;
        start    = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (v.poke && c == 3) begin
                start    = 1'b1;
                key_size = (v.key_size == 2'b10) ? 2'b00 : 2'b10;
                decrypt  = ~v.decrypt;
            end
            if (v.poke && c == 4) begin
                start    = 1'b0;
                key_size = v.key_size;
                decrypt  = v.decrypt;
            end
            for (int d = 0; d < 2; d++) begin
                if (ke_o[d]) kc[d]++;
                if (de_o[d]) begin
                    e = v.decrypt ? v.nr - dc[d] : dc[d];
                    if (int'(idx_o[d]) != e) ok[d] = 1'b0;
                    if (fr_o[d] != (dc[d] == 0)) ok[d] = 1'b0;
                    if (lr_o[d] != (dc[d] == v.nr)) ok[d] = 1'b0;
                    dc[d]++;
                end else if (fr_o[d] || lr_o[d]) begin
                    ok[d] = 1'b0;
                end
                if (cfg_o[d]) ok[d] = 1'b0;
                if (int'(ke_o[d]) + int'(de_o[d]) + int'(ov_o[d]) > 1) excl[d] = 1'b0;
                if (ov_o[d] && lat[d] < 0) begin
                    lat[d]  = c;
                    fidx[d] = int'(idx_o[d]);
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && !busy_o[0] && !busy_o[1]) break;
        end
        check({name, " latency KEY_LAT=1"}, lat[0], v.lat1);
        check({name, " latency KEY_LAT=3"}, lat[1], v.lat1 + 2);
        check({name, " key_exp_en cycles KEY_LAT=1"}, kc[0], 1);
        check({name, " key_exp_en cycles KEY_LAT=3"}, kc[1], 3);
        check({name, " data_en cycles A"}, dc[0], v.nr + 1);
        check({name, " data_en cycles B"}, dc[1], v.nr + 1);
        check({name, " idx/first/last sequence A"}, int'(ok[0]), 1);
        check({name, " idx/first/last sequence B"}, int'(ok[1]), 1);
        check({name, " enables exclusive A"}, int'(excl[0]), 1);
        check({name, " enables exclusive B"}, int'(excl[1]), 1);
        check({name, " final idx A"}, fidx[0], v.final_idx);
        check({name, " final idx B"}, fidx[1], v.final_idx);
    endtask

    initial begin
        bit found;
        bit hold_ok;

        //          key_size decrypt nr  lat1 final poke
        vecs[0] = '{2'b00, 1'b0, 10, 13, 10, 1'b0};
        vecs[1] = '{2'b10, 1'b1, 14, 17,  0, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 12, 15, 12, 1'b0};
        vecs[3] = '{2'b01, 1'b1, 12, 15,  0, 1'b1};
        vecs[4] = '{2'b00, 1'b1, 10, 13,  0, 1'b1};
        vecs[5] = '{2'b10, 1'b0, 14, 17, 14, 1'b0};

        tick();
        tick();
        check("reset outputs A", outs(0), 0);
        check("reset outputs B", outs(1), 0);
        reset = 1'b0;
        tick();
        tick();
        check("idle after reset A", outs(0), 0);
        check("idle after reset B", outs(1), 0);

        for (int i = 0; i < 6; i++) trace($sformatf("vec%0d", i), vecs[i]);

        // Illegal key size: single cfg_err pulse, never busy.
        key_size = 2'b11;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_err pulse A", int'(cfg_o[0]), 1);
        check("cfg_err pulse B", int'(cfg_o[1]), 1);
        check("cfg_err busy A", int'(busy_o[0]), 0);
        tick();
        check("cfg_err cleared A", int'(cfg_o[0]), 0);
        check("cfg_err busy later A", int'(busy_o[0]), 0);
        trace("after_cfg_err", vecs[0]);

        // Result held in DONE while out_ready is low.
        out_ready = 1'b0;
        key_size  = 2'b01;
        decrypt   = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (ov_o[0]) found = 1'b1;
            else tick();
        end
        check("done reached", int'(found), 1);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(ov_o[0] && idx_o[0] == 4'd12 && busy_o[0])) hold_ok = 1'b0;
            if (i >= 2 && !(ov_o[1] && idx_o[1] == 4'd12)) hold_ok = 1'b0;
        end
        check("done hold", int'(hold_ok), 1);
        out_ready = 1'b1;
        tick();
        check("release idle A", outs(0), 0);
        check("release idle B", outs(1), 0);

        // Abort at round 5 with start in the same cycle.
        key_size = 2'b00;
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (de_o[0] && idx_o[0] == 4'd5) found = 1'b1;
            else tick();
        end
        check("abort point reached", int'(found), 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort outputs A", outs(0), 0);
        check("abort outputs B", outs(1), 0);
        tick();
        check("abort stays idle A", outs(0), 0);
        trace("after_abort", vecs[0]);

        // Async reset between edges while in ROUND.
        key_size = 2'b00;
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (de_o[0]) found = 1'b1;
            else tick();
        end
        check("round reached before reset", int'(found), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset outputs A", outs(0), 0);
        check("async reset outputs B", outs(1), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check("post reset idle A", outs(0), 0);
        check("post reset idle B", outs(1), 0);
        trace("after_reset", vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
